// File: rtl/jtag_lock_pkg.sv
// Shared types for the key-protected debug register bank.
// State encoding and audit counter width used by FSM and bank.
package jtag_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED,
    CHECK,
    UNLOCKED,
    LOCKOUT
  } lock_state_e;

  localparam int AUDIT_CNT_W = 8;

endpackage

// File: rtl/jtag_lock_fsm.sv
// Lock FSM: state, captured key, wrong-key attempt counter.
// LOCKOUT is sticky; only reset_n leaves it.
module jtag_lock_fsm
  import jtag_lock_pkg::*;
#(
  parameter int               KEY_W        = 16,
  parameter logic [KEY_W-1:0] UNLOCK_KEY   = 16'hA5C3,
  parameter int               MAX_ATTEMPTS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             lock_req,
  input  logic             unlock_req,
  input  logic [KEY_W-1:0] unlock_key,
  output lock_state_e      state
);

  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

  logic [KEY_W-1:0] key_q;
  logic [ATT_W-1:0] attempts;
  logic [ATT_W-1:0] att_nxt;
  logic             key_ok;

  assign att_nxt = attempts + ATT_W'(1);
  assign key_ok  = (key_q == UNLOCK_KEY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= LOCKED;
      key_q    <= '0;
      attempts <= '0;
    end else begin
      unique case (state)
        LOCKED: begin
          if (unlock_req) begin
            state <= CHECK;
            key_q <= unlock_key;
          end
        end
        CHECK: begin
          if (key_ok) begin
            state    <= UNLOCKED;
            attempts <= '0;
          end else begin
            attempts <= att_nxt;
            state    <= (32'(att_nxt) == MAX_ATTEMPTS) ?
                        LOCKOUT : LOCKED;
          end
        end
        UNLOCKED: begin
          if (lock_req) state <= LOCKED;
        end
        LOCKOUT: state <= LOCKOUT;
      endcase
    end
  end

endmodule

// File: rtl/jtag_lock_regbank.sv
// Key-gated debug config register bank with registered reads.
// Optional `LOCK_AUDIT_EN adds a saturating rejected-write counter.
module jtag_lock_regbank
  import jtag_lock_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                NUM_REGS     = 4,
  parameter int                KEY_W        = 16,
  parameter logic [KEY_W-1:0]  UNLOCK_KEY   = 16'hA5C3,
  parameter int                MAX_ATTEMPTS = 3,
  parameter logic [DATA_W-1:0] RST_VAL      = '0,
  localparam int               ADDR_W       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  input  logic                   lock_req,
  input  logic                   unlock_req,
  input  logic [KEY_W-1:0]       unlock_key,
  output logic                   locked,
  output logic                   lockout,
  output logic                   wr_err,
  output logic [AUDIT_CNT_W-1:0] deny_cnt
);

  lock_state_e       state;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;
  logic              wr_rej;
  logic              rd_ok;

  jtag_lock_fsm #(
    .KEY_W       (KEY_W),
    .UNLOCK_KEY  (UNLOCK_KEY),
    .MAX_ATTEMPTS(MAX_ATTEMPTS)
  ) u_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .lock_req  (lock_req),
    .unlock_req(unlock_req),
    .unlock_key(unlock_key),
    .state     (state)
  );

  // A simultaneous relock beats the write.
  assign wr_ok = wr_en && (state == UNLOCKED) && !lock_req &&
                 (32'(wr_addr) < NUM_REGS);
  assign wr_rej = wr_en && !wr_ok;
  assign rd_ok  = (state != LOCKOUT) && (32'(rd_addr) < NUM_REGS);

  assign locked  = (state != UNLOCKED);
  assign lockout = (state == LOCKOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
      rd_data <= '0;
      wr_err  <= 1'b0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      rd_data <= rd_ok ? regs[rd_addr] : '0;
      wr_err  <= wr_rej;
    end
  end

`ifdef LOCK_AUDIT_EN
  logic [AUDIT_CNT_W-1:0] deny_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deny_q <= '0;
    end else if (wr_rej && (deny_q != '1)) begin
      deny_q <= deny_q + AUDIT_CNT_W'(1);
    end
  end

  assign deny_cnt = deny_q;
`else
  assign deny_cnt = '0;
`endif

endmodule

// File: tb/tb_jtag_lock_regbank.sv
// Directed self-checking bench for jtag_lock_regbank.
// Expected deny_cnt values follow `LOCK_AUDIT_EN.
module tb_jtag_lock_regbank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        lock_req;
  logic        unlock_req;
  logic [15:0] unlock_key;
  logic        locked;
  logic        lockout;
  logic        wr_err;
  logic [7:0]  deny_cnt;

  int compared   = 0;
  int mismatched = 0;

  jtag_lock_regbank dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .lock_req  (lock_req),
    .unlock_req(unlock_req),
    .unlock_key(unlock_key),
    .locked    (locked),
    .lockout   (lockout),
    .wr_err    (wr_err),
    .deny_cnt  (deny_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_deny(input int n);
`ifdef LOCK_AUDIT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return (n > 0) ? 8'h00 : 8'h00;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en      = 1'b0;
    lock_req   = 1'b0;
    unlock_req = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = 2'd0;
    wr_data    = 8'h00;
    rd_addr    = 2'd0;
    lock_req   = 1'b0;
    unlock_req = 1'b0;
    unlock_key = 16'h0000;
    repeat (2) step();
    reset_n = 1'b1;
    step();

    check("rst_locked", 32'(locked), 32'd1);
    check("rst_lockout", 32'(lockout), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_deny", 32'(deny_cnt), 32'h0);
    check("rst_rd", 32'(rd_data), 32'h0);

    // 1: write while locked
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h5A; rd_addr = 2'd1;
    step();
    idle();
    check("t1_wr_err", 32'(wr_err), 32'd1);
    check("t1_deny", 32'(deny_cnt), 32'(exp_deny(1)));
    check("t1_locked", 32'(locked), 32'd1);
    step();
    check("t1_wr_err_pulse", 32'(wr_err), 32'd0);
    check("t1_reg1", 32'(rd_data), 32'h00);

    // 2: unlock, write, read
    unlock_req = 1'b1; unlock_key = 16'hA5C3;
    step();
    idle();
    check("t2_check_locked", 32'(locked), 32'd1);
    step();
    check("t2_unlocked", 32'(locked), 32'd0);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h3C;
    step();
    idle();
    check("t2_wr_ok", 32'(wr_err), 32'd0);
    rd_addr = 2'd2;
    step();
    check("t2_rd", 32'(rd_data), 32'h3C);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h77;
    step();
    idle();
    check("t2_rd_old", 32'(rd_data), 32'h3C);
    step();
    check("t2_rd_new", 32'(rd_data), 32'h77);

    // 4: relock and write in same cycle
    lock_req = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF;
    step();
    idle();
    check("t4_locked", 32'(locked), 32'd1);
    check("t4_wr_err", 32'(wr_err), 32'd1);
    check("t4_deny", 32'(deny_cnt), 32'(exp_deny(2)));
    rd_addr = 2'd0;
    step();
    check("t4_reg0", 32'(rd_data), 32'h00);

    // 3: three wrong keys -> lockout
    for (int i = 0; i < 3; i++) begin
      unlock_req = 1'b1; unlock_key = 16'h0000;
      step();
      idle();
      step();
      if (i == 1) check("t3_not_yet", 32'(lockout), 32'd0);
    end
    check("t3_lockout", 32'(lockout), 32'd1);
    check("t3_locked", 32'(locked), 32'd1);
    unlock_req = 1'b1; unlock_key = 16'hA5C3;
    step();
    idle();
    step();
    check("t3_key_ignored", 32'(lockout), 32'd1);
    check("t3_still_locked", 32'(locked), 32'd1);
    rd_addr = 2'd2;
    step();
    check("t3_rd_zero", 32'(rd_data), 32'h00);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h11;
    step();
    idle();
    check("t3_wr_err", 32'(wr_err), 32'd1);
    check("t3_deny", 32'(deny_cnt), 32'(exp_deny(3)));
    lock_req = 1'b1;
    step();
    idle();
    check("t3_sticky", 32'(lockout), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t3_rst_lockout", 32'(lockout), 32'd0);
    check("t3_rst_deny", 32'(deny_cnt), 32'h0);
    #2 reset_n = 1'b1;
    step();
    check("t3_reg2_reset", 32'(rd_data), 32'h00);

    // 5: async reset during CHECK
    unlock_req = 1'b1; unlock_key = 16'h1234;
    step();
    idle();
    step();
    check("t5_attempt1", 32'(dut.u_fsm.attempts), 32'd1);
    unlock_req = 1'b1; unlock_key = 16'hA5C3;
    wr_en = 1'b1; wr_addr = 2'd3;
    step();
    idle();
    check("t5_in_check_err", 32'(wr_err), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_locked", 32'(locked), 32'd1);
    check("t5_rst_wr_err", 32'(wr_err), 32'd0);
    check("t5_rst_deny", 32'(deny_cnt), 32'h0);
    check("t5_rst_attempts", 32'(dut.u_fsm.attempts), 32'd0);
    #2 reset_n = 1'b1;
    step();
    step();
    check("t5_stays_locked", 32'(locked), 32'd1);
    check("t5_no_lockout", 32'(lockout), 32'd0);

    // 6: deny counter saturation
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hAA;
    for (int i = 0; i < 260; i++) step();
    idle();
    check("t6_wr_err", 32'(wr_err), 32'd1);
    check("t6_deny_sat", 32'(deny_cnt), 32'(exp_deny(260)));
    step();
    check("t6_deny_hold", 32'(deny_cnt), 32'(exp_deny(260)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
